// File: rtl/prefix_sum_pipe.sv
// prefix_sum_pipe: sum stage of the parallel-prefix adder.
// Carries are resolved from group P/G and cin, then the sum, carry-out and
// signed overflow leave through a two-stage valid/ready pipeline.
module prefix_sum_pipe #(
    parameter int unsigned width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width:1]   p,
    input  logic [width:1]   P,
    input  logic [width:1]   G,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width:1]   sum,
    output logic             cout,
    output logic             ovf
);

    logic [width:0] c_next;
    logic [width:0] s1_c;
    logic [width:1] s1_p;
    logic           s1_valid;
    logic           s2_valid;
    logic           s1_advance;
    logic           s1_accept;
    logic [width:1] sum_next;
    logic           cout_next;
    logic           ovf_next;

    // Carry vector: c_0 is the carry-in, c_i comes from the group span i..1.
    always_comb begin
        c_next    = '0;
        c_next[0] = cin;
        for (int unsigned i = 1; i <= width; i++) begin
            c_next[i] = G[i] | (P[i] & cin);
        end
    end

    // Handshake: S1 hands its set to S2 whenever S2 is empty or draining.
    // in_ready depends on out_ready so a full pipe can pop and push together.
    always_comb begin
        s1_advance = s1_valid & (~s2_valid | out_ready);
        in_ready   = ~s1_valid | s1_advance;
        s1_accept  = in_valid & in_ready;
        out_valid  = s2_valid;
    end

    // Final sum bits, carry-out and signed overflow from the S1 registers.
    always_comb begin
        sum_next  = s1_p ^ s1_c[width-1:0];
        cout_next = s1_c[width];
        ovf_next  = s1_c[width] ^ s1_c[width-1];
    end

    // Stage 1: capture bitwise propagate and the full carry vector on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_c     <= '0;
        end else begin
            if (s1_accept) begin
                s1_valid <= 1'b1;
                s1_p     <= p;
                s1_c     <= c_next;
            end else if (s1_advance) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2: load the result when S1 advances, hold it while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (s1_advance) begin
                s2_valid <= 1'b1;
                sum      <= sum_next;
                cout     <= cout_next;
                ovf      <= ovf_next;
            end else if (out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prefix_sum_pipe.sv
// Self-checking bench for prefix_sum_pipe: three instances (width 3, 8, 16)
// share the clock and stimulus buses; one instance is active at a time.
// Expected results come from plain a+b+cin arithmetic.
module tb_prefix_sum_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [16:1] p_d, P_d, G_d;
    logic        cin_d;
    int          cur;
    int unsigned cur_w;

    logic iv [3];
    logic ir [3];
    logic ov [3];
    logic [3:1]  sum3;
    logic [8:1]  sum8;
    logic [16:1] sum16;
    logic cout_o [3];
    logic ovf_o  [3];

    logic        ir_c, ov_c;
    logic [17:0] obs_c;

    int n_tests = 0;
    int n_fail  = 0;
    int n_acc   = 0;

    logic [17:0] q [$];
    logic [17:0] drv_exp;
    logic [17:0] held;
    logic        stall_prev;

    always #5 clk = ~clk;

    prefix_sum_pipe #(.width(3)) u_w3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .p(p_d[3:1]), .P(P_d[3:1]), .G(G_d[3:1]), .cin(cin_d),
        .out_valid(ov[0]), .out_ready(out_ready), .sum(sum3),
        .cout(cout_o[0]), .ovf(ovf_o[0]));

    prefix_sum_pipe #(.width(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .p(p_d[8:1]), .P(P_d[8:1]), .G(G_d[8:1]), .cin(cin_d),
        .out_valid(ov[1]), .out_ready(out_ready), .sum(sum8),
        .cout(cout_o[1]), .ovf(ovf_o[1]));

    prefix_sum_pipe #(.width(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .p(p_d), .P(P_d), .G(G_d), .cin(cin_d),
        .out_valid(ov[2]), .out_ready(out_ready), .sum(sum16),
        .cout(cout_o[2]), .ovf(ovf_o[2]));

    // Route the shared in_valid to the active instance and view its outputs.
    always_comb begin
        iv[0] = in_valid && (cur == 0);
        iv[1] = in_valid && (cur == 1);
        iv[2] = in_valid && (cur == 2);
        ir_c  = 1'b0;
        ov_c  = 1'b0;
        obs_c = '0;
        case (cur)
            0: begin ir_c = ir[0]; ov_c = ov[0]; obs_c = {ovf_o[0], cout_o[0], 16'(sum3)}; end
            1: begin ir_c = ir[1]; ov_c = ov[1]; obs_c = {ovf_o[1], cout_o[1], 16'(sum8)}; end
            default: begin ir_c = ir[2]; ov_c = ov[2]; obs_c = {ovf_o[2], cout_o[2], sum16}; end
        endcase
    end

    task automatic chk(input string tag, input logic [17:0] o, input logic [17:0] e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    // Reference: ripple-free arithmetic view of an a+b+cin add of width w.
    function automatic void gen(input int unsigned w, input logic [63:0] a_in, input logic [63:0] b_in,
                                input logic ci, output logic [16:1] pv, output logic [16:1] pgv,
                                output logic [16:1] ggv, output logic [17:0] ex);
        logic [63:0] mask, a, b, full, s, m, gs;
        logic co, ov;
        mask = (64'd1 << w) - 64'd1;
        a    = a_in & mask;
        b    = b_in & mask;
        full = a + b + {63'd0, ci};
        s    = full & mask;
        co   = full[w];
        ov   = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
        pv   = 16'(a ^ b);
        pgv  = '0;
        ggv  = '0;
        for (int i = 1; i <= int'(w); i++) begin
            m      = (64'd1 << i) - 64'd1;
            gs     = (a & m) + (b & m);
            ggv[i] = gs[i];
            pgv[i] = (((a ^ b) & m) == m);
        end
        ex = {ov, co, s[15:0]};
    endfunction

    task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic ci);
        logic [16:1] pv, pgv, ggv;
        logic [17:0] ex;
        gen(cur_w, a, b, ci, pv, pgv, ggv, ex);
        p_d = pv; P_d = pgv; G_d = ggv; cin_d = ci; drv_exp = ex;
    endtask

    // One clock: sample handshakes at the falling edge, update the scoreboard,
    // then return 1 time unit after the next rising edge.
    task automatic step();
        @(negedge clk);
        if (stall_prev) chk("stable_while_stalled", obs_c, held);
        if (ov_c && out_ready) begin
            chk("pop_has_expected", 18'(q.size() != 0), 18'd1);
            if (q.size() != 0) chk("out_data", obs_c, q.pop_front());
        end
        if (in_valid && ir_c) begin
            q.push_back(drv_exp);
            n_acc++;
        end
        stall_prev = ov_c && !out_ready;
        held       = obs_c;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 8 && q.size() != 0; k++) step();
        chk("drain_empty", 18'(q.size()), 18'd0);
        step();
    endtask

    task automatic sel(input int d, input int unsigned w);
        cur = d; cur_w = w; stall_prev = 1'b0;
    endtask

    initial begin
        int acc0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        p_d = '0; P_d = '0; G_d = '0; cin_d = 1'b0; drv_exp = '0;
        held = '0; stall_prev = 1'b0;
        sel(1, 8);
        #12;
        chk("reset_out", {ov_c, obs_c[16:0]}, '0);
        chk("reset_in_ready", 18'(ir_c), 18'd1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed: 0x5A + 0x3C, visible after the second edge.
        out_ready = 1'b1; in_valid = 1'b1;
        drive(64'h5A, 64'h3C, 1'b0);
        step();
        in_valid = 1'b0;
        chk("lat_edge1_empty", 18'(ov_c), 18'd0);
        step();
        chk("lat_edge2_valid", 18'(ov_c), 18'd1);
        chk("dir_5a_3c", obs_c, {1'b1, 1'b0, 16'h0096});
        drain();

        in_valid = 1'b1; drive(64'hFF, 64'h01, 1'b0); step();
        in_valid = 1'b1; drive(64'h7F, 64'h00, 1'b1); step();
        in_valid = 1'b0;
        chk("dir_ff_01", obs_c, {1'b0, 1'b1, 16'h0000});
        step();
        chk("dir_7f_00_c1", obs_c, {1'b1, 1'b0, 16'h0080});
        drain();

        // Stream of 16 with out_ready held high: one output per cycle.
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            drive(64'($urandom), 64'($urandom), 1'($urandom));
            step();
            chk("stream_valid", 18'(ov_c), 18'(i >= 1));
        end
        in_valid = 1'b0;
        step();
        chk("stream_last_valid", 18'(ov_c), 18'd1);
        step();
        chk("stream_done", 18'(ov_c), 18'd0);
        drain();

        // Full pipe: two accepted, third blocked, then pop+push together.
        acc0 = n_acc;
        out_ready = 1'b0; in_valid = 1'b1;
        drive(64'h12, 64'h34, 1'b0);
        chk("full_rdy_a", 18'(ir_c), 18'd1);
        step();
        drive(64'h80, 64'h80, 1'b1);
        chk("full_rdy_b", 18'(ir_c), 18'd1);
        step();
        drive(64'h0F, 64'hF0, 1'b1);
        chk("full_rdy_c_blocked", 18'(ir_c), 18'd0);
        step();
        step();
        chk("full_head", obs_c, {1'b0, 1'b0, 16'h0046});
        out_ready = 1'b1;
        #1;
        chk("full_pop_push_rdy", 18'(ir_c), 18'd1);
        step();
        in_valid = 1'b0;
        drain();
        chk("full_accept_count", 18'(n_acc - acc0), 18'd3);

        // Asynchronous reset with both stages holding data.
        out_ready = 1'b0; in_valid = 1'b1;
        drive(64'hAB, 64'hCD, 1'b1); step();
        drive(64'h11, 64'h22, 1'b0); step();
        in_valid = 1'b0;
        chk("pre_reset_valid", 18'(ov_c), 18'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_reset_out", {ov_c, obs_c[16:0]}, '0);
        chk("mid_reset_in_ready", 18'(ir_c), 18'd1);
        q.delete(); stall_prev = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1;
        drive(64'h33, 64'h44, 1'b0);
        step();
        in_valid = 1'b0;
        chk("post_reset_edge1", 18'(ov_c), 18'd0);
        step();
        chk("post_reset_data", obs_c, {1'b0, 1'b0, 16'h0077});
        drain();

        // Random valid/ready traffic on width 3 and width 16.
        for (int d = 0; d < 3; d += 2) begin
            sel(d, (d == 0) ? 3 : 16);
            for (int c = 0; c < 500; c++) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 2) != 0);
                drive(64'($urandom), 64'($urandom), 1'($urandom));
                step();
            end
            drain();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
